// File: rtl/frame_unscramble_pkg.sv
// Shared constants for the 9-slot frame unscrambler: frame geometry, the slot
// permutation and the read-engine state type.
package frame_unscramble_pkg;

  localparam int FRAME_LEN = 9;
  localparam int SLOT_W    = 4;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 4'd8;

  // Scrambled slot s carries natural index PERM[s]; the table is self-inverse.
  localparam logic [SLOT_W-1:0] PERM [FRAME_LEN] = '{
    4'd0, 4'd1, 4'd3, 4'd2, 4'd4, 4'd6, 4'd5, 4'd7, 4'd8
  };

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  function automatic logic [SLOT_W-1:0] perm_idx(input logic [SLOT_W-1:0] slot);
    perm_idx = (slot <= LAST_SLOT) ? PERM[slot] : '0;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame buffer of the ping-pong pair: indexed write, combinational read
// by natural index, and a full flag owned jointly by the write and read sides.
module frame_bank
  import frame_unscramble_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              set_full_i,
  input  logic              clr_full_i,
  input  logic [SLOT_W-1:0] rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [FRAME_LEN];
  logic              full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_idx_i <= LAST_SLOT)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Set wins over clear; the two never coincide on one bank in legal traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (set_full_i) begin
      full_q <= 1'b1;
    end else if (clr_full_i) begin
      full_q <= 1'b0;
    end
  end

  assign rd_data_o = (rd_idx_i <= LAST_SLOT) ? mem_q[rd_idx_i] : '0;
  assign full_o    = full_q;

endmodule

// File: rtl/frame_unscramble.sv
// Receive-side unscrambler: fills one bank in scrambled slot order while the
// other drains in natural order, giving gapless output for continuous input.
module frame_unscramble
  import frame_unscramble_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              frame_err
);

  // Handshake: in_valid has no backpressure, every valid byte is taken on the
  // edge it is presented; out_valid is a pure strobe with no ready.

  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_err_q, frame_err_d;
  logic [SLOT_W-1:0] wr_idx;
  logic              frame_done;
  logic              sync_err;

  rd_state_t         rd_state_q, rd_state_d;
  logic [SLOT_W-1:0] rd_idx_q, rd_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [SLOT_W-1:0] rd_sel_idx;
  logic              rd_start;
  logic              rd_last;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;

  logic [DATA_W-1:0] bank0_rd_data, bank1_rd_data, rd_data;
  logic              bank0_full, bank1_full, rd_bank_full;

  // ---------------- write side ----------------
  always_comb begin
    sync_err    = in_valid && in_sof && (wr_slot_q != '0);
    wr_slot_d   = wr_slot_q;
    wr_bank_d   = wr_bank_q;
    frame_done  = 1'b0;
    wr_idx      = perm_idx(wr_slot_q);
    frame_err_d = sync_err;
    if (in_valid) begin
      if (sync_err) begin
        // Resynchronise: the sof byte becomes slot 0 of a fresh frame.
        wr_idx    = perm_idx('0);
        wr_slot_d = 4'd1;
      end else if (wr_slot_q == LAST_SLOT) begin
        wr_slot_d  = '0;
        wr_bank_d  = ~wr_bank_q;
        frame_done = 1'b1;
      end else begin
        wr_slot_d = wr_slot_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot_q   <= '0;
      wr_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_slot_q   <= wr_slot_d;
      wr_bank_q   <= wr_bank_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------- ping-pong banks ----------------
  frame_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (in_valid && !wr_bank_q),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (in_data),
    .set_full_i (frame_done && !wr_bank_q),
    .clr_full_i (rd_last && !rd_bank_q),
    .rd_idx_i   (rd_sel_idx),
    .rd_data_o  (bank0_rd_data),
    .full_o     (bank0_full)
  );

  frame_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (in_valid && wr_bank_q),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (in_data),
    .set_full_i (frame_done && wr_bank_q),
    .clr_full_i (rd_last && rd_bank_q),
    .rd_idx_i   (rd_sel_idx),
    .rd_data_o  (bank1_rd_data),
    .full_o     (bank1_full)
  );

  assign rd_data      = rd_bank_q ? bank1_rd_data : bank0_rd_data;
  assign rd_bank_full = rd_bank_q ? bank1_full : bank0_full;

  // ---------------- read engine: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
    end
  end

  // ---------------- read engine: next state ----------------
  // Index 0 leaves on the idle->drain edge, so the drain state walks 1..8.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_bank_d  = rd_bank_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_bank_full) begin
          rd_state_d = RD_DRAIN;
          rd_idx_d   = 4'd1;
        end
      end
      RD_DRAIN: begin
        if (rd_idx_q == LAST_SLOT) begin
          rd_state_d = RD_IDLE;
          rd_idx_d   = '0;
          rd_bank_d  = ~rd_bank_q;
        end else begin
          rd_idx_d = rd_idx_q + 4'd1;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        rd_idx_d   = '0;
      end
    endcase
  end

  // ---------------- read engine: outputs ----------------
  always_comb begin
    rd_start    = (rd_state_q == RD_IDLE) && rd_bank_full;
    rd_last     = (rd_state_q == RD_DRAIN) && (rd_idx_q == LAST_SLOT);
    rd_sel_idx  = (rd_state_q == RD_DRAIN) ? rd_idx_q : '0;
    out_valid_d = rd_start || (rd_state_q == RD_DRAIN);
    out_sof_d   = rd_start;
    out_data_d  = out_valid_d ? rd_data : out_data_q;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_unscramble.sv
// Directed plus randomized bench for frame_unscramble against a frame-level
// reference model (collect nine bytes, swap pairs 2/3 and 5/6, schedule output).
module tb_frame_unscramble;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_unscramble #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .frame_err (frame_err)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       sof;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_scr[$];
  int         cyc;
  int         next_free;
  logic [7:0] last_d;
  logic       exp_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_scr.delete();
    next_free = 0;
    last_d    = 8'h00;
    exp_err   = 1'b0;
  endtask

  // Called at the edge numbered cyc with the inputs sampled on it.
  task automatic model_accept(input logic v, input logic sof, input logic [7:0] d);
    logic [7:0] nat[9];
    logic [7:0] t;
    int         start;
    exp_t       e;
    exp_err = 1'b0;
    if (v) begin
      if (sof && m_scr.size() != 0) begin
        exp_err = 1'b1;
        m_scr.delete();
      end
      m_scr.push_back(d);
      if (m_scr.size() == 9) begin
        for (int i = 0; i < 9; i++) nat[i] = m_scr[i];
        t = nat[2]; nat[2] = nat[3]; nat[3] = t;
        t = nat[5]; nat[5] = nat[6]; nat[6] = t;
        start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        for (int i = 0; i < 9; i++) begin
          e.cyc = start + i;
          e.d   = nat[i];
          e.sof = (i == 0);
          exp_q.push_back(e);
        end
        next_free = start + 9;
        m_scr.delete();
      end
    end
  endtask

  task automatic check_outputs();
    logic       ev, es;
    logic [7:0] ed;
    exp_t       e;
    ev = 1'b0;
    es = 1'b0;
    ed = last_d;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e      = exp_q.pop_front();
      ev     = 1'b1;
      es     = e.sof;
      ed     = e.d;
      last_d = e.d;
    end
    chk("out_valid", {7'd0, out_valid}, {7'd0, ev});
    chk("out_sof",   {7'd0, out_sof},   {7'd0, es});
    chk("out_data",  out_data, ed);
    chk("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic sof, input logic [7:0] d);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    cyc++;
    model_accept(v, sof, d);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap_after2, input int gap_after6);
    logic [7:0] scr[9];
    scr = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h04, 8'h06, 8'h05, 8'h07, 8'h08};
    for (int s = 0; s < 9; s++) begin
      step(1'b1, (s == 0), base | scr[s]);
      if (s == 2) idle(gap_after2);
      if (s == 6) idle(gap_after6);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_async_sof",   {7'd0, out_sof},   8'd0);
    chk("rst_async_data",  out_data, 8'h00);
    chk("rst_async_err",   {7'd0, frame_err}, 8'd0);
    @(posedge clk);
    cyc++;
    #1;
    chk("rst_held_valid", {7'd0, out_valid}, 8'd0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    cyc      = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_sof",   {7'd0, out_sof},   8'd0);
    chk("reset_data",  out_data, 8'h00);
    chk("reset_err",   {7'd0, frame_err}, 8'd0);
    idle(2);

    // Single frame, continuous valid
    send_frame(8'h00, 0, 0);
    idle(12);

    // Two back-to-back frames
    send_frame(8'h00, 0, 0);
    send_frame(8'h10, 0, 0);
    idle(20);

    // Gaps of three cycles after slots 2 and 6
    send_frame(8'h00, 3, 3);
    idle(12);

    // Sof at slot 4 discards the partial frame
    for (int s = 0; s < 4; s++) step(1'b1, (s == 0), 8'hA0 + 8'(s));
    send_frame(8'h20, 0, 0);
    idle(12);

    // Reset while index 3 (0x03) is on the output
    send_frame(8'h00, 0, 0);
    idle(4);
    chk("pre_reset_data", out_data, 8'h03);
    apply_reset();
    idle(12);
    send_frame(8'h30, 0, 0);
    idle(12);

    // Sof without valid at slot 5 is ignored
    for (int s = 0; s < 5; s++) step(1'b1, (s == 0), 8'h40 + 8'(s));
    step(1'b0, 1'b1, 8'hEE);
    for (int s = 5; s < 9; s++) step(1'b1, 1'b0, 8'h40 + 8'(s));
    idle(12);

    // Randomized traffic with occasional misplaced sof
    for (int i = 0; i < 400; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      if (m_scr.size() == 0) s = v && ($urandom_range(0, 7) != 0);
      else                   s = v && ($urandom_range(0, 39) == 0);
      step(v, s, 8'($urandom));
    end
    idle(25);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_unscramble.md
Name: frame_unscramble

Overview:
- Receive-side companion to the 9-slot byte scrambler.
- Accepts a byte stream whose frame slots arrive in the fixed scrambled order, buffers one complete frame, and re-emits it in natural order.
- Ping-pong buffered so continuous input yields continuous output.
- Sits between the scrambled link and downstream byte consumers.

Parameters:
DATA_W, 8, width of each stream element

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  DATA_W  scrambled stream element
in_valid  input  1  in_data valid this cycle (no backpressure; always accepted)
in_sof  input  1  qualified by in_valid; marks scrambled slot 0 of a frame
out_data  output  DATA_W  unscrambled element
out_valid  output  1  out_data valid this cycle
out_sof  output  1  high with the first (index 0) element of each output frame
frame_err  output  1  one-cycle pulse on a framing error

Behaviour:
- One clock (clk); rst is asynchronous, active-high; all state clears immediately on assertion.
- Reset values:
  - out_data=0, out_valid=0, out_sof=0, frame_err=0.
  - Write slot counter=0; write-bank select=0.
  - Both banks marked empty; read engine idle.
- Frame length FRAME_LEN=9; slot counter wr_slot 0..8, 4 bits.
- Permutation PERM (scrambled slot s carries natural index PERM[s]): {0,1,3,2,4,6,5,7,8}. The table is its own inverse.
- Write side, on each in_valid:
  - Store in_data into write bank at index PERM[wr_slot].
  - wr_slot increments.
  - After slot 8 is stored: wr_slot wraps to 0, the bank is marked full, and write-bank select toggles.
- Synchronisation:
  - in_sof && in_valid with wr_slot==0: normal frame start.
  - in_sof && in_valid with wr_slot!=0:
    - frame_err pulses for one cycle, the cycle after.
    - Partial frame is discarded; the bank stays empty.
    - Current byte is stored as slot 0; wr_slot becomes 1.
  - in_valid at wr_slot==0 without in_sof is accepted as slot 0 (no error).
  - in_sof without in_valid is ignored.
- Read side:
  - When a bank becomes full at edge T, the read engine emits its indices 0..8 on edges T+1..T+9.
  - out_valid=1 for those nine cycles; out_sof=1 only with index 0.
  - The bank is marked empty after index 8 is emitted.
  - out_data holds its last value when out_valid=0.
- Latency: last scrambled byte accepted at edge T gives natural index 0 at T+1 and index 8 at T+9.
- No collision is possible: a fill takes ≥9 valid cycles and a drain takes exactly 9. Back-to-back frames produce gapless output; the next drain starts on the edge after the previous index 8.
- Gaps in in_valid only delay frame completion; they never stall a drain in progress.
- Reset mid-operation: out_valid drops asynchronously; partial and buffered frames are lost; after release, output resumes only once a new complete frame is received.

Decomposition:
- Package frame_unscramble_pkg:
  - FRAME_LEN=9, SLOT_W=4.
  - PERM constant array, plus function perm_idx(slot) returning the natural index.
- Sub-module frame_bank:
  - FRAME_LEN x DATA_W register file.
  - Indexed synchronous write; combinational read by index; full flag with set and clear inputs.
  - Instantiated twice (ping-pong).
- Top level holds the slot counter, bank select, read engine (idle/drain with a 0..8 index), and error pulse.

Test Plan:
1. After reset, one frame with in_valid continuous: in_sof at the first byte, data 0x00,0x01,0x03,0x02,0x04,0x06,0x05,0x07,0x08 → out_data 0x00..0x08 on nine consecutive cycles starting one cycle after the last input; out_sof only with 0x00; frame_err stays 0.
2. Two back-to-back frames: second frame scrambled 0x10,0x11,0x13,0x12,0x14,0x16,0x15,0x17,0x18 → 18 consecutive out_valid cycles, 0x00..0x08 then 0x10..0x18, out_sof exactly twice.
3. Same frame with in_valid low for 3 cycles after slots 2 and 6 → identical output sequence 0x00..0x08, starting one cycle after the last valid byte, gapless.
4. in_sof asserted at wr_slot=4, followed by a full valid frame (the sof byte as slot 0) → frame_err one-cycle pulse; first partial frame produces no output; the new frame comes out correctly unscrambled.
5. rst asserted while out_data=0x03 is being driven → out_valid=0 immediately and nothing further is output; after release, a new full frame produces correct output.
6. in_sof=1 with in_valid=0 at wr_slot=5, then the remaining slots 5..8 valid → no frame_err; frame output normally.
